// File: rtl/fifo_axis_packetizer_if.sv
// fifo_axis_packetizer_if: AXI4-Stream channel carrying packetized FIFO words
interface fifo_axis_packetizer_if #(
    parameter int DATA_WIDTH_P = 64
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH_P-1:0] tdata;
    logic                    tlast;
    modport master (output tvalid, tdata, tlast, input tready);
    modport slave (input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/fifo_axis_packetizer.sv
// fifo_axis_packetizer: drains a FIFO read port into AXI4-Stream packets framed by length or idle timeout
module fifo_axis_packetizer #(
    parameter int DATA_WIDTH_P = 64,
    parameter int LEN_WIDTH_P  = 8,
    parameter int TMO_WIDTH_P  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    o_egr_enable,
    input  logic [DATA_WIDTH_P-1:0] i_egr_data,
    input  logic                    i_egr_empty,
    input  logic [LEN_WIDTH_P-1:0]  i_cr_pkt_len,
    input  logic [TMO_WIDTH_P-1:0]  i_cr_timeout,
    fifo_axis_packetizer_if.master  m_axis,
    output logic [31:0]             o_sr_pkt_count,
    output logic [15:0]             o_sr_flush_count
);
    logic                    r_h_valid;
    logic [DATA_WIDTH_P-1:0] r_h_data;
    logic                    r_h_last;
    logic [LEN_WIDTH_P-1:0]  r_word_cnt;
    logic [TMO_WIDTH_P-1:0]  r_tmo_cnt;
    logic                    r_tvalid;
    logic [DATA_WIDTH_P-1:0] r_tdata;
    logic                    r_tlast;
    logic [31:0]             r_pkt_count;
    logic [15:0]             r_flush_count;
    logic                    w_o_free;
    logic                    w_tmo_hit;
    logic                    w_move;
    logic                    w_tmo_move;
    logic                    w_pop;
    logic                    w_new_last;
    logic [LEN_WIDTH_P:0]    w_cnt_inc;
    logic [LEN_WIDTH_P:0]    w_len_eff;
    // a word arriving alongside a saturated timeout wins: the held word leaves as a normal non-last beat
    always_comb begin
        w_o_free         = !r_tvalid | m_axis.tready;
        w_tmo_hit        = (i_cr_timeout != '0) & (r_tmo_cnt == i_cr_timeout);
        w_move           = r_h_valid & w_o_free & (r_h_last | !i_egr_empty | w_tmo_hit);
        w_tmo_move       = w_move & w_tmo_hit & i_egr_empty & !r_h_last;
        w_pop            = !rst & !i_egr_empty & (!r_h_valid | w_move);
        w_cnt_inc        = {1'b0, r_word_cnt} + (LEN_WIDTH_P+1)'(1);
        w_len_eff        = (i_cr_pkt_len == '0) ? (LEN_WIDTH_P+1)'(1) : {1'b0, i_cr_pkt_len};
        w_new_last       = w_cnt_inc >= w_len_eff;
        o_egr_enable     = w_pop;
        m_axis.tvalid    = r_tvalid;
        m_axis.tdata     = r_tdata;
        m_axis.tlast     = r_tlast;
        o_sr_pkt_count   = r_pkt_count;
        o_sr_flush_count = r_flush_count;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_valid  <= 1'b0;
            r_h_data   <= '0;
            r_h_last   <= 1'b0;
            r_word_cnt <= '0;
        end else if (w_pop) begin
            r_h_valid  <= 1'b1;
            r_h_data   <= i_egr_data;
            r_h_last   <= w_new_last;
            r_word_cnt <= w_new_last ? '0 : r_word_cnt + LEN_WIDTH_P'(1);
        end else begin
            r_h_valid  <= r_h_valid & !w_move;
            r_word_cnt <= w_tmo_move ? '0 : r_word_cnt;
        end
    end
    // idle count only runs while a non-last word waits on an empty FIFO; it parks at the limit
    always_ff @(posedge clk) begin
        if (rst | !(r_h_valid & !r_h_last & i_egr_empty))
            r_tmo_cnt <= '0;
        else
            r_tmo_cnt <= (r_tmo_cnt >= i_cr_timeout) ? i_cr_timeout : r_tmo_cnt + TMO_WIDTH_P'(1);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else if (w_move) begin
            r_tvalid <= 1'b1;
            r_tdata  <= r_h_data;
            r_tlast  <= r_h_last | w_tmo_move;
        end else if (m_axis.tready) begin
            r_tvalid <= 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pkt_count   <= '0;
            r_flush_count <= '0;
        end else begin
            r_pkt_count   <= r_pkt_count + 32'(r_tvalid & m_axis.tready & r_tlast);
            r_flush_count <= r_flush_count + 16'(w_tmo_move);
        end
    end
endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// tb_fifo_axis_packetizer: directed and randomized checks of framing, timeout, backpressure and reset against a packet-level model
module tb_fifo_axis_packetizer;
    localparam int DW = 64;
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            due;
    } exp_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          egr_en;
    logic          egr_empty;
    logic [DW-1:0] egr_data;
    logic [7:0]    pkt_len;
    logic [15:0]   timeout;
    logic [31:0]   pkt_cnt;
    logic [15:0]   flush_cnt;
    fifo_axis_packetizer_if #(.DATA_WIDTH_P(DW)) axis ();
    fifo_axis_packetizer dut (
        .clk             (clk),
        .rst             (rst),
        .o_egr_enable    (egr_en),
        .i_egr_data      (egr_data),
        .i_egr_empty     (egr_empty),
        .i_cr_pkt_len    (pkt_len),
        .i_cr_timeout    (timeout),
        .m_axis          (axis),
        .o_sr_pkt_count  (pkt_cnt),
        .o_sr_flush_count(flush_cnt)
    );
    always #5 clk = ~clk;
    exp_t          exp_q[$];
    logic [DW-1:0] fifo[$];
    int            checks, errors, cyc, idx, pend_c, m_pkts, m_flush;
    int            beats, gaps, first_pop, first_beat, last_beat, pushed, len_i, tmo_i;
    bit            pend, prev_stall;
    logic [DW-1:0] pend_d, prev_d;
    logic          prev_l;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input int n);
        repeat (n) fifo.push_back({$urandom, $urandom});
    endtask
    task automatic apply();
        egr_empty = (fifo.size() == 0);
        egr_data  = (fifo.size() != 0) ? fifo[0] : '0;
        pkt_len   = 8'(len_i);
        timeout   = 16'(tmo_i);
    endtask
    // model: a word is last when it fills the packet, or when no further pop follows within timeout+1 cycles
    task automatic step();
        bit   pop, beat;
        exp_t e;
        apply();
        #1;
        if (tmo_i != 0 && pend && cyc == pend_c + tmo_i + 2) begin
            exp_q.push_back('{pend_d, 1'b1, cyc});
            pend = 0;
            idx  = 0;
            m_flush++;
        end
        pop = egr_en;
        chk("en_while_empty", 64'(pop & egr_empty), 64'(0));
        if (rst) chk("en_in_rst", 64'(pop), 64'(0));
        if (pop) begin
            if (first_pop < 0) first_pop = cyc;
            if (pend) exp_q.push_back('{pend_d, 1'b0, -1});
            pend = 0;
            idx++;
            if (idx >= ((len_i == 0) ? 1 : len_i)) begin
                exp_q.push_back('{fifo[0], 1'b1, -1});
                idx = 0;
            end else begin
                pend   = 1;
                pend_d = fifo[0];
                pend_c = cyc;
            end
        end
        if (prev_stall) begin
            chk("hold_valid", 64'(axis.tvalid), 64'(1));
            chk("hold_data", axis.tdata, prev_d);
            chk("hold_last", 64'(axis.tlast), 64'(prev_l));
        end
        beat = axis.tvalid & axis.tready;
        if (beat) begin
            if (exp_q.size() == 0) chk("spurious_beat", 64'(beat), 64'(0));
            else begin
                e = exp_q.pop_front();
                chk("tdata", axis.tdata, e.d);
                chk("tlast", 64'(axis.tlast), 64'(e.l));
                if (e.due >= 0) chk("flush_time", 64'(cyc), 64'(e.due));
                if (e.l) m_pkts++;
            end
            if (beats > 0 && cyc != last_beat + 1) gaps++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            beats++;
        end
        prev_stall = axis.tvalid & !axis.tready;
        prev_d     = axis.tdata;
        prev_l     = axis.tlast;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (pop) void'(fifo.pop_front());
        apply();
    endtask
    function automatic bit busy();
        return fifo.size() != 0 || exp_q.size() != 0 || pend || axis.tvalid === 1'b1;
    endfunction
    task automatic drain(input int n);
        for (int i = 0; i < n && busy(); i++) step();
        chk("drain_done", 64'(busy()), 64'(0));
    endtask
    task automatic new_test(input int l, input int t);
        len_i      = l;
        tmo_i      = t;
        beats      = 0;
        gaps       = 0;
        first_pop  = -1;
        first_beat = -1;
    endtask
    initial begin
        checks = 0; errors = 0; cyc = 0; idx = 0; pend = 0; prev_stall = 0;
        m_pkts = 0; m_flush = 0; pushed = 0;
        axis.tready = 1'b1;
        new_test(1, 0);
        apply();
        @(negedge clk);
        repeat (3) step();
        chk("rst_tvalid", 64'(axis.tvalid), 64'(0));
        chk("rst_tlast", 64'(axis.tlast), 64'(0));
        chk("rst_tdata", axis.tdata, 64'(0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("rst_flush_cnt", 64'(flush_cnt), 64'(0));
        rst = 1'b0;
        new_test(1, 0);
        push(4);
        drain(50);
        chk("t1_latency", 64'(first_beat - first_pop), 64'(2));
        chk("t1_beats", 64'(beats), 64'(4));
        chk("t1_pkts", 64'(pkt_cnt), 64'(m_pkts));
        new_test(4, 0);
        push(12);
        drain(60);
        chk("t2_gaps", 64'(gaps), 64'(0));
        chk("t2_beats", 64'(beats), 64'(12));
        chk("t2_pkts", 64'(pkt_cnt), 64'(m_pkts));
        new_test(8, 10);
        push(3);
        drain(60);
        chk("t3_flush_cnt", 64'(flush_cnt), 64'(m_flush));
        chk("t3_beats", 64'(beats), 64'(3));
        push(8);
        drain(60);
        chk("t3_pkts", 64'(pkt_cnt), 64'(m_pkts));
        new_test(8, 10);
        push(3);
        repeat (3) step();
        repeat (4) step();
        push(5);
        drain(80);
        chk("t4_flush_cnt", 64'(flush_cnt), 64'(m_flush));
        chk("t4_pkts", 64'(pkt_cnt), 64'(m_pkts));
        new_test(4, 0);
        pushed = 0;
        for (int i = 0; i < 300; i++) begin
            if (pushed < 40 && $urandom_range(0, 1) == 1) begin
                push(1);
                pushed++;
            end
            axis.tready = 1'($urandom_range(0, 1));
            step();
        end
        push(40 - pushed);
        axis.tready = 1'b1;
        drain(300);
        chk("t5_beats", 64'(beats), 64'(40));
        chk("t5_pkts", 64'(pkt_cnt), 64'(m_pkts));
        new_test(4, 0);
        axis.tready = 1'b0;
        push(6);
        repeat (6) step();
        chk("t6_o_full", 64'(axis.tvalid), 64'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        fifo.delete();
        pend = 0; idx = 0; m_pkts = 0; m_flush = 0; prev_stall = 0;
        chk("t6_tvalid", 64'(axis.tvalid), 64'(0));
        chk("t6_pkt_cnt", 64'(pkt_cnt), 64'(0));
        chk("t6_flush_cnt", 64'(flush_cnt), 64'(0));
        axis.tready = 1'b1;
        new_test(4, 0);
        push(4);
        drain(40);
        chk("t6_beats", 64'(beats), 64'(4));
        chk("t6_pkts", 64'(pkt_cnt), 64'(m_pkts));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
